// File: rtl/apb_pkg.sv
// ---------------------------------------------------------------------------
// apb_pkg
// Shared definitions for the two-port APB master arbiter.
//   apb_state_t : bus sequencer states (IDLE -> SETUP -> ACCESS -> IDLE)
//   CR/ODR/IDR  : register offsets of the GPIO peripheral normally attached
//                 behind the arbiter (control, output data, input data)
// ---------------------------------------------------------------------------
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_t;

  localparam int unsigned CR  = 32'h0;
  localparam int unsigned ODR = 32'h4;
  localparam int unsigned IDR = 32'h8;

endpackage

// File: rtl/rr_arbiter2.sv
// ---------------------------------------------------------------------------
// rr_arbiter2
// Purely combinational two-way round-robin arbiter. The owner of the
// round-robin pointer (the top module) feeds back the index granted last.
// Ports:
//   req   [1:0] in  : request vector, bit i = requester i
//   last        in  : index of the requester granted most recently
//   grant [1:0] out : one-hot grant, all zero when nothing is requested
// ---------------------------------------------------------------------------
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] grant
);

  always_comb begin
    grant = req;
    // On a tie the requester that did not win last time gets the bus.
    if (req == 2'b11) begin
      grant = last ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/apb_master_arbiter.sv
// ---------------------------------------------------------------------------
// apb_master_arbiter
// Shares one APB slave between two requesters. A round-robin arbiter picks a
// winner in IDLE, the sequencer runs SETUP/ACCESS on the bus and the result
// (read data or a timeout error) is returned to the winner.
//
// Ports:
//   PCLK, PRESET            clock, synchronous active-high reset
//   req_valid/req_write [1:0], req_addr, req_wdata (packed per requester)
//   req_ready [1:0]         combinational accept pulse
//   rsp_valid [1:0]         registered one-cycle completion pulse
//   rsp_rdata, rsp_err      completion payload, valid with rsp_valid
//   PSEL, PENABLE, PWRITE, PADDR, PWDATA, PRDATA, PREADY   APB master side
//   dbg_state [1:0]         current sequencer state (apb_state_t encoding)
//
// Handshake: a requester raises req_valid[i] with stable write/addr/wdata and
// keeps them until it sees req_ready[i] high; the request is taken on the
// rising edge that ends the req_ready[i] cycle. Dropping req_valid[i] before
// that edge withdraws the request. rsp_valid[i] is a single-cycle pulse with
// no back-pressure.
// ---------------------------------------------------------------------------
module apb_master_arbiter
  import apb_pkg::*;
#(
  parameter int ADDR_W  = 4,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic [1:0]            req_valid,
  input  logic [1:0]            req_write,
  input  logic [2*ADDR_W-1:0]   req_addr,
  input  logic [2*DATA_W-1:0]   req_wdata,
  output logic [1:0]            req_ready,
  output logic [1:0]            rsp_valid,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic                  rsp_err,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [ADDR_W-1:0]     PADDR,
  output logic [DATA_W-1:0]     PWDATA,
  input  logic [DATA_W-1:0]     PRDATA,
  input  logic                  PREADY,
  output logic [1:0]            dbg_state
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

  apb_state_t         state_q, state_d;
  logic               last_q, last_d;       // round-robin pointer
  logic               gnt_q, gnt_d;         // index of the requester being served
  logic [CNT_W-1:0]   cnt_q, cnt_d;         // ACCESS cycle count, 1-based
  logic               pwrite_q, pwrite_d;
  logic [ADDR_W-1:0]  paddr_q, paddr_d;
  logic [DATA_W-1:0]  pwdata_q, pwdata_d;
  logic [1:0]         rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]  rsp_rdata_q, rsp_rdata_d;
  logic               rsp_err_q, rsp_err_d;

  logic [1:0]         arb_grant;
  logic [1:0]         ready_c;
  logic               win;

  rr_arbiter2 u_arb (
    .req   (req_valid),
    .last  (last_q),
    .grant (arb_grant)
  );

  // Grant is one-hot whenever any request is present, so bit 1 is the index.
  assign win = arb_grant[1];

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    gnt_d       = gnt_q;
    cnt_d       = cnt_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = 2'b00;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    ready_c     = 2'b00;

    case (state_q)
      IDLE: begin
        if (req_valid != 2'b00) begin
          ready_c  = arb_grant;
          gnt_d    = win;
          last_d   = win;
          pwrite_d = req_write[win];
          paddr_d  = win ? req_addr[2*ADDR_W-1:ADDR_W]  : req_addr[ADDR_W-1:0];
          pwdata_d = win ? req_wdata[2*DATA_W-1:DATA_W] : req_wdata[DATA_W-1:0];
          cnt_d    = '0;
          state_d  = SETUP;
        end
      end

      SETUP: begin
        // PREADY is deliberately not looked at here: the slave may still be
        // holding it from the previous transfer.
        cnt_d   = CNT_W'(1);
        state_d = ACCESS;
      end

      ACCESS: begin
        if (PREADY) begin
          // Ready wins even in the final allowed cycle.
          rsp_valid_d[gnt_q] = 1'b1;
          rsp_rdata_d        = pwrite_q ? '0 : PRDATA;
          rsp_err_d          = 1'b0;
          state_d            = IDLE;
        end else if (cnt_q == TIMEOUT_C) begin
          rsp_valid_d[gnt_q] = 1'b1;
          rsp_rdata_d        = '0;
          rsp_err_d          = 1'b1;
          state_d            = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q     <= IDLE;
      last_q      <= 1'b1;
      gnt_q       <= 1'b0;
      cnt_q       <= '0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 2'b00;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      gnt_q       <= gnt_d;
      cnt_q       <= cnt_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // A request seen during reset would be dropped by the reset edge, so it
  // must not be acknowledged.
  assign req_ready = ready_c & {2{~PRESET}};

  assign PSEL      = (state_q != IDLE);
  assign PENABLE   = (state_q == ACCESS);
  assign PWRITE    = pwrite_q;
  assign PADDR     = paddr_q;
  assign PWDATA    = pwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_apb_master_arbiter.sv
// ---------------------------------------------------------------------------
// tb_apb_master_arbiter
// Directed bench for apb_master_arbiter (TIMEOUT=4) with a GPIO-like slave
// model: CR/ODR registers, IDR = pins, one wait state, PREADY left high
// after a transfer. Responses are checked against an expected queue.
// ---------------------------------------------------------------------------
module tb_apb_master_arbiter;
  import apb_pkg::*;

  localparam int ADDR_W  = 4;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 4;
  localparam int W       = 2 + 1 + DATA_W;

  localparam logic [ADDR_W-1:0] A_CR  = ADDR_W'(CR);
  localparam logic [ADDR_W-1:0] A_ODR = ADDR_W'(ODR);
  localparam logic [ADDR_W-1:0] A_IDR = ADDR_W'(IDR);

  // ---------------- clock / reset ----------------
  logic PCLK = 1'b0;
  logic PRESET;
  always #5 PCLK = ~PCLK;

  logic [1:0]          req_valid, req_write, req_ready, rsp_valid, dbg_state;
  logic [2*ADDR_W-1:0] req_addr;
  logic [2*DATA_W-1:0] req_wdata;
  logic [DATA_W-1:0]   rsp_rdata, PWDATA, PRDATA;
  logic                rsp_err, PSEL, PENABLE, PWRITE, PREADY;
  logic [ADDR_W-1:0]   PADDR;

  apb_master_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
    .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .dbg_state(dbg_state)
  );

  // ---------------- GPIO slave model ----------------
  logic [DATA_W-1:0] cr = '0, odr = '0, gpio_in = '0;
  logic p1 = 1'b0, p2 = 1'b0, stuck = 1'b0;

  always @(posedge PCLK) begin
    p1 <= PSEL & PENABLE;
    p2 <= p1;
    if (PSEL && PENABLE && PREADY && PWRITE) begin
      if (PADDR == A_CR)  cr  <= PWDATA;
      if (PADDR == A_ODR) odr <= PWDATA;
    end
  end

  assign PREADY = ~stuck & (p1 | p2);

  always_comb begin
    PRDATA = '0;
    if (PADDR == A_CR)  PRDATA = cr;
    if (PADDR == A_ODR) PRDATA = odr;
    if (PADDR == A_IDR) PRDATA = (gpio_in & ~cr) | (odr & cr);
  end

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  bit started = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  always @(negedge PCLK) begin
    if (started && rsp_valid !== 2'b00) begin
      if (exp_q.size() == 0) begin
        check("rsp_unexpected", 64'({rsp_valid, rsp_err, rsp_rdata}), 64'(0));
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        check("rsp", 64'({rsp_valid, rsp_err, rsp_rdata}), 64'(e));
      end
    end
  end

  // ---------------- driver ----------------
  // Call at posedge+1; returns at posedge+1 of the cycle after the grant (t1).
  task automatic issue(input int idx, input logic wr, input logic [ADDR_W-1:0] addr,
                       input logic [DATA_W-1:0] wdata, input logic [DATA_W-1:0] exp_rdata,
                       input logic exp_err, input bit push);
    logic [1:0] onehot;
    bit seen;
    onehot = (idx == 0) ? 2'b01 : 2'b10;
    req_valid[idx] = 1'b1;
    req_write[idx] = wr;
    req_addr[idx*ADDR_W +: ADDR_W]  = addr;
    req_wdata[idx*DATA_W +: DATA_W] = wdata;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge PCLK);
      if (req_ready != 2'b00) seen = 1'b1;
    end
    check("grant_seen", 64'(seen), 64'(1));
    check("grant_idx", 64'(req_ready), 64'(onehot));
    if (seen && push) exp_q.push_back({onehot, exp_err, exp_rdata});
    @(posedge PCLK); #1;
    req_valid[idx] = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, bad, grants;
    bit done, seen;
    logic [1:0] onehot;

    PRESET = 1'b1; req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    repeat (3) @(posedge PCLK);
    #1 PRESET = 1'b0;
    started = 1'b1;

    // ---- reset state ----
    @(negedge PCLK);
    check("rst_psel", 64'(PSEL), 64'(0));
    check("rst_penable", 64'(PENABLE), 64'(0));
    check("rst_pwrite", 64'(PWRITE), 64'(0));
    check("rst_paddr", 64'(PADDR), 64'(0));
    check("rst_pwdata", 64'(PWDATA), 64'(0));
    check("rst_ready", 64'(req_ready), 64'(0));
    check("rst_rsp", 64'({rsp_valid, rsp_err, rsp_rdata}), 64'(0));
    check("rst_state", 64'(dbg_state), 64'(IDLE));

    // ---- write 0xA5 to ODR from requester 0 ----
    @(posedge PCLK); #1;
    issue(0, 1'b1, A_ODR, 32'hA5, 32'h0, 1'b0, 1'b1);
    @(negedge PCLK);  // t1
    check("w_t1_sel", 64'({PSEL, PENABLE}), 64'(2'b10));
    check("w_t1_ctl", 64'({PWRITE, PADDR, PWDATA}), 64'({1'b1, A_ODR, 32'hA5}));
    @(negedge PCLK);  // t2
    check("w_t2_sel", 64'({PSEL, PENABLE}), 64'(2'b11));
    @(negedge PCLK);  // t3
    check("w_t3_sel", 64'({PSEL, PENABLE}), 64'(2'b11));
    @(negedge PCLK);  // t4
    check("w_t4_sel", 64'({PSEL, PENABLE}), 64'(2'b00));
    check("w_t4_rsp", 64'({rsp_valid, rsp_err}), 64'(3'b010));
    check("w_odr", 64'(odr), 64'(32'hA5));

    // ---- read IDR from requester 1 ----
    @(posedge PCLK); #1;
    issue(1, 1'b1, A_CR, 32'h0, 32'h0, 1'b0, 1'b1);
    repeat (4) @(posedge PCLK);
    #1 gpio_in = 32'h5A;
    issue(1, 1'b0, A_IDR, 32'h0, 32'h5A, 1'b0, 1'b1);
    repeat (3) @(negedge PCLK);
    @(negedge PCLK);  // t4
    check("r_t4_valid", 64'(rsp_valid), 64'(2'b10));
    check("r_t4_data", 64'(rsp_rdata), 64'(32'h5A));

    // ---- timeout with PREADY stuck low ----
    repeat (2) @(posedge PCLK);
    #1 stuck = 1'b1;
    issue(0, 1'b0, A_IDR, 32'h0, 32'h0, 1'b1, 1'b1);
    acc = 0; done = 1'b0;
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge PCLK);
      if (PENABLE) acc++;
      else if (!PSEL) done = 1'b1;
    end
    check("to_done", 64'(done), 64'(1));
    check("to_access_cycles", 64'(acc), 64'(TIMEOUT));
    check("to_sel", 64'({PSEL, PENABLE}), 64'(2'b00));
    check("to_rsp", 64'({rsp_valid, rsp_err, rsp_rdata}), 64'({2'b01, 1'b1, 32'h0}));
    repeat (3) @(posedge PCLK);
    #1 stuck = 1'b0;
    repeat (3) @(posedge PCLK);

    // ---- reset during ACCESS ----
    #1;
    issue(1, 1'b1, A_ODR, 32'hEE, 32'h0, 1'b0, 1'b0);
    @(posedge PCLK); #1;  // t2: ACCESS
    PRESET = 1'b1;
    @(negedge PCLK);
    check("rr_in_access", 64'({PSEL, PENABLE}), 64'(2'b11));
    @(posedge PCLK); #1;
    PRESET = 1'b0;
    @(negedge PCLK);
    check("rr_apb_zero", 64'({PSEL, PENABLE, PWRITE, PADDR, PWDATA}), 64'(0));
    check("rr_rsp_zero", 64'({rsp_valid, rsp_err, rsp_rdata}), 64'(0));
    check("rr_state", 64'(dbg_state), 64'(IDLE));
    bad = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge PCLK);
      if (rsp_valid != 2'b00) bad++;
    end
    check("rr_no_rsp", 64'(bad), 64'(0));
    check("rr_odr_kept", 64'(odr), 64'(32'hA5));
    // both requesters valid after reset: requester 0 must win the tie
    @(posedge PCLK); #1;
    req_write = 2'b11;
    req_addr  = {A_ODR, A_CR};
    req_wdata = {32'h99, 32'h0};
    req_valid = 2'b11;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge PCLK);
      if (req_ready != 2'b00) seen = 1'b1;
    end
    check("rr_tie", 64'(req_ready), 64'(2'b01));
    if (seen) exp_q.push_back({2'b01, 1'b0, 32'h0});
    @(posedge PCLK); #1;
    req_valid = 2'b00;  // requester 1 withdraws
    repeat (5) @(negedge PCLK);
    check("rr_withdrawn", 64'(odr), 64'(32'hA5));

    // ---- back-to-back: write ODR then read IDR ----
    @(posedge PCLK); #1;
    gpio_in = 32'h3C;
    issue(0, 1'b1, A_ODR, 32'h77, 32'h0, 1'b0, 1'b1);
    req_write[1] = 1'b0;
    req_addr[2*ADDR_W-1:ADDR_W] = A_IDR;
    req_valid[1] = 1'b1;
    repeat (3) @(negedge PCLK);  // t1..t3
    @(negedge PCLK);  // t4
    check("b2b_grant", 64'(req_ready), 64'(2'b10));
    if (req_ready == 2'b10) exp_q.push_back({2'b10, 1'b0, 32'h3C});
    @(posedge PCLK); #1;
    req_valid = 2'b00;
    @(negedge PCLK);  // t5: SETUP with leftover PREADY
    check("b2b_setup", 64'({PSEL, PENABLE}), 64'(2'b10));
    @(negedge PCLK);  // t6
    check("b2b_access1", 64'({PSEL, PENABLE}), 64'(2'b11));
    @(negedge PCLK);  // t7
    check("b2b_access2", 64'({PSEL, PENABLE}), 64'(2'b11));
    @(negedge PCLK);  // t8
    check("b2b_rsp", 64'({rsp_valid, rsp_rdata}), 64'({2'b10, 32'h3C}));
    check("b2b_odr", 64'(odr), 64'(32'h77));

    // ---- round robin with both held valid after reset ----
    @(posedge PCLK); #1;
    PRESET = 1'b1;
    @(posedge PCLK); #1;
    PRESET = 1'b0;
    req_write = 2'b00;
    req_addr  = {A_IDR, A_ODR};
    req_valid = 2'b11;
    grants = 0;
    for (int c = 0; c < 40 && grants < 4; c++) begin
      @(negedge PCLK);
      if (req_ready != 2'b00) begin
        onehot = (grants % 2 == 0) ? 2'b01 : 2'b10;
        check("rr_order", 64'(req_ready), 64'(onehot));
        exp_q.push_back({onehot, 1'b0, (grants % 2 == 0) ? 32'h77 : 32'h3C});
        grants++;
      end
    end
    check("rr_grants", 64'(grants), 64'(4));
    @(posedge PCLK); #1;
    req_valid = 2'b00;
    for (int c = 0; c < 20 && exp_q.size() != 0; c++) @(negedge PCLK);
    check("drain", 64'(exp_q.size()), 64'(0));

    repeat (2) @(posedge PCLK);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
